// File: rtl/seq_value_checker.sv
// seq_value_checker: programmable stream-integrity checker.
// Loads N_PROG operands, then checks N_CHECK data beats against a
// per-step reduction (AND/OR/XOR/ADD) of those operands.
module seq_value_checker #(
   parameter int DATA_W  = 8,
   parameter int N_PROG  = 2,
   parameter int N_CHECK = 3,
   parameter int IDX_W   = $clog2(N_CHECK + 1)
) (
   input  logic                   clk_i,
   input  logic                   rstn_i,
   input  logic                   start_i,
   input  logic [2*N_CHECK-1:0]   op_cfg_i,
   input  logic                   early_exit_i,
   input  logic                   prog_valid_i,
   input  logic [DATA_W-1:0]      prog_data_i,
   output logic                   prog_ready_o,
   input  logic                   valid_i,
   input  logic [DATA_W-1:0]      data_i,
   output logic                   ready_o,
   output logic                   busy_o,
   output logic                   valid_o,
   output logic                   pass_o,
   output logic [IDX_W-1:0]       fail_idx_o,
   output logic [IDX_W-1:0]       fail_cnt_o
);

   localparam int PW = (N_PROG > 1) ? $clog2(N_PROG) : 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_PROG,
      S_CHECK,
      S_DONE
   } state_t;

   state_t              state;
   logic [PW-1:0]       prog_cnt;
   logic [IDX_W-1:0]    chk_cnt;
   logic [IDX_W-1:0]    fail_idx;
   logic [IDX_W-1:0]    fail_cnt;
   logic                pass_q;
   logic                early_q;
   logic [DATA_W-1:0]   operand [N_PROG];
   logic [1:0]          op_q    [N_CHECK];

   logic [DATA_W-1:0]   red_and;
   logic [DATA_W-1:0]   red_or;
   logic [DATA_W-1:0]   red_xor;
   logic [DATA_W-1:0]   red_add;
   logic [DATA_W-1:0]   exp_val;
   logic                mismatch;
   logic                last_chk;

   // Reductions over all operands and selection of the current step's expected value
   always_comb begin
      red_and = '1;
      red_or  = '0;
      red_xor = '0;
      red_add = '0;
      for (int unsigned i = 0; i < N_PROG; i++) begin
         red_and = red_and & operand[i];
         red_or  = red_or  | operand[i];
         red_xor = red_xor ^ operand[i];
         red_add = red_add + operand[i];
      end
      exp_val = '0;
      if (chk_cnt < IDX_W'(N_CHECK)) begin
         case (op_q[chk_cnt])
            2'b00:   exp_val = red_and;
            2'b01:   exp_val = red_or;
            2'b10:   exp_val = red_xor;
            default: exp_val = red_add;
         endcase
      end
      mismatch = (data_i != exp_val);
      last_chk = (chk_cnt == IDX_W'(N_CHECK - 1));
   end

   // Control FSM with counters, operand store and result registers
   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         state    <= S_IDLE;
         prog_cnt <= '0;
         chk_cnt  <= '0;
         fail_idx <= '0;
         fail_cnt <= '0;
         pass_q   <= 1'b0;
         early_q  <= 1'b0;
         for (int unsigned i = 0; i < N_PROG; i++) operand[i] <= '0;
         for (int unsigned k = 0; k < N_CHECK; k++) op_q[k] <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start_i) begin
                  for (int unsigned k = 0; k < N_CHECK; k++) op_q[k] <= op_cfg_i[2*k +: 2];
                  early_q  <= early_exit_i;
                  prog_cnt <= '0;
                  chk_cnt  <= '0;
                  fail_idx <= '0;
                  fail_cnt <= '0;
                  pass_q   <= 1'b0;
                  state    <= S_PROG;
               end
            end
            S_PROG: begin
               if (prog_valid_i) begin
                  operand[prog_cnt] <= prog_data_i;
                  prog_cnt          <= prog_cnt + PW'(1);
                  if (prog_cnt == PW'(N_PROG - 1)) state <= S_CHECK;
               end
            end
            S_CHECK: begin
               if (valid_i) begin
                  chk_cnt <= chk_cnt + IDX_W'(1);
                  if (mismatch) begin
                     fail_cnt <= fail_cnt + IDX_W'(1);
                     if (fail_idx == '0) fail_idx <= chk_cnt + IDX_W'(1);
                  end
                  if (last_chk || (mismatch && early_q)) begin
                     // pass reflects the count including this deciding beat
                     pass_q <= (fail_cnt == '0) && !mismatch;
                     state  <= S_DONE;
                  end
               end
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

   assign prog_ready_o = (state == S_PROG);
   assign ready_o      = (state == S_CHECK);
   assign busy_o       = (state != S_IDLE);
   assign valid_o      = (state == S_DONE);
   assign pass_o       = pass_q;
   assign fail_idx_o   = fail_idx;
   assign fail_cnt_o   = fail_cnt;

endmodule
